// File: rtl/bus_pkg.sv
// Shared types for the two-master bus arbiter: request/response bundles,
// tag widths and the arbitration state encoding.
package bus_pkg;

  localparam int MASTER_ID_W = 1;
  localparam int TAG_W       = 8;
  localparam int DEC_TAG_W   = MASTER_ID_W + TAG_W;

  typedef struct packed {
    logic             write;
    logic [31:0]      address;
    logic [3:0]       wstrb;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } bus_req_t;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [TAG_W-1:0] rtag;
  } bus_resp_t;

  // Plain constants keep the encoding stable for older tools and netlists.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE     = 2'd0;
  localparam arb_state_t LOCKED_0 = 2'd1;
  localparam arb_state_t LOCKED_1 = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two masters, the arbiter and the address decoder.
// The slave modport is the arbiter's view; master is the surrounding system.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic                 m0_request, m0_ready, m0_write, m0_lock;
  logic [31:0]          m0_address, m0_wdata;
  logic [3:0]           m0_wstrb;
  logic [TAG_W-1:0]     m0_tag;
  logic                 m0_rvalid;
  logic [31:0]          m0_rdata;
  logic [TAG_W-1:0]     m0_rtag;

  logic                 m1_request, m1_ready, m1_write, m1_lock;
  logic [31:0]          m1_address, m1_wdata;
  logic [3:0]           m1_wstrb;
  logic [TAG_W-1:0]     m1_tag;
  logic                 m1_rvalid;
  logic [31:0]          m1_rdata;
  logic [TAG_W-1:0]     m1_rtag;

  logic                 dec_request, dec_write;
  logic [31:0]          dec_address, dec_wdata;
  logic [3:0]           dec_wstrb;
  logic [DEC_TAG_W-1:0] dec_tag;
  logic                 dec_rvalid;
  logic [31:0]          dec_rdata;
  logic [DEC_TAG_W-1:0] dec_rtag;
  logic                 err_orphan;

  modport slave (
    input  m0_request, m0_write, m0_address, m0_wstrb, m0_wdata, m0_tag, m0_lock,
    output m0_ready, m0_rvalid, m0_rdata, m0_rtag,
    input  m1_request, m1_write, m1_address, m1_wstrb, m1_wdata, m1_tag, m1_lock,
    output m1_ready, m1_rvalid, m1_rdata, m1_rtag,
    output dec_request, dec_write, dec_address, dec_wstrb, dec_wdata, dec_tag,
    input  dec_rvalid, dec_rdata, dec_rtag,
    output err_orphan
  );

  modport master (
    output m0_request, m0_write, m0_address, m0_wstrb, m0_wdata, m0_tag, m0_lock,
    input  m0_ready, m0_rvalid, m0_rdata, m0_rtag,
    output m1_request, m1_write, m1_address, m1_wstrb, m1_wdata, m1_tag, m1_lock,
    input  m1_ready, m1_rvalid, m1_rdata, m1_rtag,
    input  dec_request, dec_write, dec_address, dec_wstrb, dec_wdata, dec_tag,
    output dec_rvalid, dec_rdata, dec_rtag,
    input  err_orphan
  );

endinterface

// File: rtl/bus_arbiter_outstanding_counter.sv
// Per-master count of reads in flight. Saturates at MAX and at zero; a
// response arriving while the count is zero is reported on orphan.
module outstanding_counter #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic orphan
);

  localparam logic [3:0] LIMIT = 4'(MAX);

  logic [3:0] count;

  assign full   = (count >= LIMIT);
  assign orphan = dec && (count == 4'd0);

  // A grant and a response in the same cycle cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 4'd0;
    end else if (inc && !dec && !full) begin
      count <= count + 4'd1;
    end else if (dec && !inc && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with beat locking between the CPU data port (M0) and
// the DMA/blitter (M1), feeding the address decoder and routing responses back.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING      = 4,
  parameter int M0_PRIORITY_ON_RESET = 1
) (
  input logic          clock,
  input logic          reset_n,
  bus_arbiter_if.slave bus
);

  logic       full_0, full_1, orphan_0, orphan_1;
  logic       eligible_0, eligible_1, grant_0, grant_1;
  logic       resp_for_0, resp_for_1;
  logic       rr_ptr;
  arb_state_t state, state_next;
  bus_req_t   sel_req, dec_req_q;
  logic       dec_request_q, dec_id_q;
  bus_resp_t  resp_0_q, resp_1_q;
  logic       rvalid_0_q, rvalid_1_q, err_q;

  // Writes never wait on the read limit.
  assign eligible_0 = bus.m0_request & (bus.m0_write | ~full_0);
  assign eligible_1 = bus.m1_request & (bus.m1_write | ~full_1);
  assign resp_for_0 = bus.dec_rvalid & ~bus.dec_rtag[DEC_TAG_W-1];
  assign resp_for_1 = bus.dec_rvalid &  bus.dec_rtag[DEC_TAG_W-1];

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    case (state)
      LOCKED_0: grant_0 = eligible_0;
      LOCKED_1: grant_1 = eligible_1;
      default: begin
        if (eligible_0 && eligible_1) begin
          grant_0 = ~rr_ptr;
          grant_1 = rr_ptr;
        end else begin
          grant_0 = eligible_0;
          grant_1 = eligible_1;
        end
      end
    endcase
  end

  // A locked master that is only throttled by its read limit keeps the lock.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_0 && bus.m0_lock)      state_next = LOCKED_0;
        else if (grant_1 && bus.m1_lock) state_next = LOCKED_1;
      end
      LOCKED_0: if (!bus.m0_request || (grant_0 && !bus.m0_lock)) state_next = IDLE;
      LOCKED_1: if (!bus.m1_request || (grant_1 && !bus.m1_lock)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= (M0_PRIORITY_ON_RESET == 0);
    end else begin
      state <= state_next;
      if (grant_0)      rr_ptr <= 1'b1;
      else if (grant_1) rr_ptr <= 1'b0;
    end
  end

  always_comb begin
    sel_req = '{write: bus.m0_write, address: bus.m0_address, wstrb: bus.m0_wstrb,
                wdata: bus.m0_wdata, tag: bus.m0_tag};
    if (grant_1) begin
      sel_req = '{write: bus.m1_write, address: bus.m1_address, wstrb: bus.m1_wstrb,
                  wdata: bus.m1_wdata, tag: bus.m1_tag};
    end
  end

  // Beat fields hold their last value when no grant is made.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_request_q <= 1'b0;
      dec_req_q     <= '0;
      dec_id_q      <= 1'b0;
    end else begin
      dec_request_q <= grant_0 | grant_1;
      if (grant_0 || grant_1) begin
        dec_req_q <= sel_req;
        dec_id_q  <= grant_1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      resp_0_q   <= '0;
      resp_1_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rvalid_0_q <= resp_for_0;
      rvalid_1_q <= resp_for_1;
      if (resp_for_0) resp_0_q <= {bus.dec_rdata, bus.dec_rtag[TAG_W-1:0]};
      if (resp_for_1) resp_1_q <= {bus.dec_rdata, bus.dec_rtag[TAG_W-1:0]};
      err_q <= err_q | orphan_0 | orphan_1;
    end
  end

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_count_0 (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (grant_0 & ~bus.m0_write),
    .dec     (resp_for_0),
    .full    (full_0),
    .orphan  (orphan_0)
  );

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_count_1 (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (grant_1 & ~bus.m1_write),
    .dec     (resp_for_1),
    .full    (full_1),
    .orphan  (orphan_1)
  );

  assign bus.m0_ready    = grant_0;
  assign bus.m1_ready    = grant_1;
  assign bus.dec_request = dec_request_q;
  assign bus.dec_write   = dec_req_q.write;
  assign bus.dec_address = dec_req_q.address;
  assign bus.dec_wstrb   = dec_req_q.wstrb;
  assign bus.dec_wdata   = dec_req_q.wdata;
  assign bus.dec_tag     = {dec_id_q, dec_req_q.tag};
  assign bus.m0_rvalid   = rvalid_0_q;
  assign bus.m0_rdata    = resp_0_q.rdata;
  assign bus.m0_rtag     = resp_0_q.rtag;
  assign bus.m1_rvalid   = rvalid_1_q;
  assign bus.m1_rdata    = resp_1_q.rdata;
  assign bus.m1_rtag     = resp_1_q.rtag;
  assign bus.err_orphan  = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: hand-computed vector table for the directed corner
// cases, then random traffic against a queue/counter reference model.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int MAXO = 4;

  typedef struct {
    logic [1:0]  req, wr, lk;
    logic [7:0]  tag0, tag1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic        rv;
    logic [8:0]  rtag;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [1:0] rdy;
    logic       dreq;
    logic [8:0] dtag;
    logic [1:0] rvo;
    logic       err;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bus_arbiter_if bus ();

  bus_arbiter #(.MAX_OUTSTANDING(MAXO), .M0_PRIORITY_ON_RESET(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // Reference model: reads in flight per master, who wins the next tie,
  // which master (if any) holds the lock, and the expected registered outputs.
  int          cnt[2];
  int          tie_winner;
  int          locked_to;
  int          grant;
  logic        exp_dreq, exp_dwrite, exp_err;
  logic [31:0] exp_daddr, exp_dwdata;
  logic [3:0]  exp_dwstrb;
  logic [8:0]  exp_dtag;
  logic        exp_rv[2];
  logic [31:0] exp_rdata[2];
  logic [7:0]  exp_rtag[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    cnt[0] = 0; cnt[1] = 0;
    tie_winner = 0;
    locked_to = -1;
    exp_dreq = 0; exp_dwrite = 0; exp_err = 0;
    exp_daddr = 0; exp_dwdata = 0; exp_dwstrb = 0; exp_dtag = 0;
    for (int n = 0; n < 2; n++) begin
      exp_rv[n] = 0; exp_rdata[n] = 0; exp_rtag[n] = 0;
    end
  endtask

  function automatic stim_t mk(input logic [1:0] req, wr, lk, input logic [7:0] t0, t1,
                               input logic rv, input logic [8:0] rtag);
    stim_t s;
    s.req = req; s.wr = wr; s.lk = lk; s.tag0 = t0; s.tag1 = t1;
    s.addr0 = 32'hA000_0000 | 32'(t0); s.wdata0 = 32'h5A5A_0000 | 32'(t0); s.wstrb0 = 4'hF;
    s.addr1 = 32'hB000_0000 | 32'(t1); s.wdata1 = 32'hA5A5_0000 | 32'(t1); s.wstrb1 = 4'h3;
    s.rv = rv; s.rtag = rtag; s.rdata = 32'hD000_0000 | 32'(rtag);
    return s;
  endfunction

  function automatic vec_t v(input logic [1:0] req, wr, lk, input logic [7:0] t0, t1,
                             input logic rv, input logic [8:0] rtag, input logic [1:0] rdy,
                             input logic dreq, input logic [8:0] dtag, input logic [1:0] rvo,
                             input logic err);
    vec_t r;
    r.s = mk(req, wr, lk, t0, t1, rv, rtag);
    r.rdy = rdy; r.dreq = dreq; r.dtag = dtag; r.rvo = rvo; r.err = err;
    return r;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    int n;
    for (int m = 0; m < 2; m++) begin
      s.req[m] = ($urandom_range(0, 3) != 0);
      s.wr[m]  = ($urandom_range(0, 2) == 0);
      s.lk[m]  = ($urandom_range(0, 4) == 0);
    end
    s.tag0 = 8'($urandom); s.tag1 = 8'($urandom);
    s.addr0 = $urandom; s.addr1 = $urandom; s.wdata0 = $urandom; s.wdata1 = $urandom;
    s.wstrb0 = 4'($urandom); s.wstrb1 = 4'($urandom);
    s.rdata = $urandom;
    s.rv = 0; s.rtag = 9'($urandom);
    if ($urandom_range(0, 1) == 1 && (cnt[0] + cnt[1]) > 0) begin
      if (cnt[0] > 0 && cnt[1] > 0) n = $urandom_range(0, 1);
      else n = (cnt[0] > 0) ? 0 : 1;
      s.rv = 1;
      s.rtag = {n[0], 8'($urandom)};
    end
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    bit elig[2];
    bit rsp, inc;
    @(negedge clock);
    bus.m0_request = s.req[0]; bus.m0_write = s.wr[0]; bus.m0_lock = s.lk[0];
    bus.m0_address = s.addr0; bus.m0_wdata = s.wdata0; bus.m0_wstrb = s.wstrb0; bus.m0_tag = s.tag0;
    bus.m1_request = s.req[1]; bus.m1_write = s.wr[1]; bus.m1_lock = s.lk[1];
    bus.m1_address = s.addr1; bus.m1_wdata = s.wdata1; bus.m1_wstrb = s.wstrb1; bus.m1_tag = s.tag1;
    bus.dec_rvalid = s.rv; bus.dec_rtag = s.rtag; bus.dec_rdata = s.rdata;

    for (int n = 0; n < 2; n++) elig[n] = s.req[n] && (s.wr[n] || cnt[n] < MAXO);
    grant = -1;
    if (locked_to >= 0) begin
      if (elig[locked_to]) grant = locked_to;
    end else if (elig[0] && elig[1]) grant = tie_winner;
    else if (elig[0]) grant = 0;
    else if (elig[1]) grant = 1;

    #1;
    check("m0_ready", 32'(bus.m0_ready), 32'(grant == 0));
    check("m1_ready", 32'(bus.m1_ready), 32'(grant == 1));

    if (locked_to >= 0 && !s.req[locked_to]) locked_to = -1;
    exp_dreq = (grant >= 0);
    if (grant >= 0) begin
      tie_winner = 1 - grant;
      locked_to = s.lk[grant] ? grant : -1;
      exp_dwrite = s.wr[grant];
      exp_daddr  = (grant == 0) ? s.addr0  : s.addr1;
      exp_dwdata = (grant == 0) ? s.wdata0 : s.wdata1;
      exp_dwstrb = (grant == 0) ? s.wstrb0 : s.wstrb1;
      exp_dtag   = (grant == 0) ? {1'b0, s.tag0} : {1'b1, s.tag1};
    end
    for (int n = 0; n < 2; n++) begin
      rsp = s.rv && (int'(s.rtag[8]) == n);
      inc = (grant == n) && !s.wr[n];
      exp_rv[n] = rsp;
      if (rsp) begin
        exp_rdata[n] = s.rdata;
        exp_rtag[n]  = s.rtag[7:0];
        if (cnt[n] == 0) exp_err = 1;
      end
      if (inc && !rsp && cnt[n] < MAXO) cnt[n]++;
      else if (rsp && !inc && cnt[n] > 0) cnt[n]--;
    end
  endtask

  task automatic checkOutput();
    check("dec_request", 32'(bus.dec_request), 32'(exp_dreq));
    check("dec_write",   32'(bus.dec_write),   32'(exp_dwrite));
    check("dec_address", bus.dec_address,      exp_daddr);
    check("dec_wstrb",   32'(bus.dec_wstrb),   32'(exp_dwstrb));
    check("dec_wdata",   bus.dec_wdata,        exp_dwdata);
    check("dec_tag",     32'(bus.dec_tag),     32'(exp_dtag));
    check("m0_rvalid",   32'(bus.m0_rvalid),   32'(exp_rv[0]));
    check("m0_rdata",    bus.m0_rdata,         exp_rdata[0]);
    check("m0_rtag",     32'(bus.m0_rtag),     32'(exp_rtag[0]));
    check("m1_rvalid",   32'(bus.m1_rvalid),   32'(exp_rv[1]));
    check("m1_rdata",    bus.m1_rdata,         exp_rdata[1]);
    check("m1_rtag",     32'(bus.m1_rtag),     32'(exp_rtag[1]));
    check("err_orphan",  32'(bus.err_orphan),  32'(exp_err));
  endtask

  task automatic runCycle(input stim_t s);
    applyStimulus(s);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic driveIdle();
    stim_t s;
    s = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 9'h000);
    bus.m0_request = 0; bus.m0_write = 0; bus.m0_lock = 0;
    bus.m0_address = s.addr0; bus.m0_wdata = s.wdata0; bus.m0_wstrb = s.wstrb0; bus.m0_tag = 0;
    bus.m1_request = 0; bus.m1_write = 0; bus.m1_lock = 0;
    bus.m1_address = s.addr1; bus.m1_wdata = s.wdata1; bus.m1_wstrb = s.wstrb1; bus.m1_tag = 0;
    bus.dec_rvalid = 0; bus.dec_rtag = 0; bus.dec_rdata = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Both read every cycle: strict alternation, M0 first after reset.
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 9'h000,
                       (i % 2 == 0) ? 2'b01 : 2'b10, 1, (i % 2 == 0) ? 9'h010 : 9'h120, 2'b00, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h010, 2'b00, 0, 9'h120, 2'b01, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h010, 2'b00, 0, 9'h120, 2'b01, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h120, 2'b00, 0, 9'h120, 2'b10, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h120, 2'b00, 0, 9'h120, 2'b10, 0));
    // M0 fills its read limit, stalls, one response frees a slot.
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'(i), 8'h00, 0, 9'h000, 2'b01, 1, 9'(i), 2'b00, 0));
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 0, 9'h000, 2'b00, 0, 9'h004, 2'b00, 0));
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 1, 9'h003, 2'b00, 0, 9'h004, 2'b01, 0));
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 0, 9'h000, 2'b01, 1, 9'h005, 2'b00, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h001, 2'b00, 0, 9'h005, 2'b01, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h002, 2'b00, 0, 9'h005, 2'b01, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h004, 2'b00, 0, 9'h005, 2'b01, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h005, 2'b00, 0, 9'h005, 2'b01, 0));
    // M1 holds the lock for three beats, then a final unlocked beat; M0 masked throughout.
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(2'b11, 2'b00, 2'b10, 8'h40, 8'h30, 0, 9'h000, 2'b10, 1, 9'h130, 2'b00, 0));
    vecs.push_back(v(2'b11, 2'b00, 2'b00, 8'h40, 8'h30, 0, 9'h000, 2'b10, 1, 9'h130, 2'b00, 0));
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h40, 8'h30, 0, 9'h000, 2'b01, 1, 9'h040, 2'b00, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h040, 2'b00, 0, 9'h040, 2'b01, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h130, 2'b00, 0, 9'h040, 2'b10, 0));
    // Grant and response for M0 in one cycle leave its count unchanged: fifth read still stalls.
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h50, 8'h00, 0, 9'h000, 2'b01, 1, 9'h050, 2'b00, 0));
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h51, 8'h00, 1, 9'h050, 2'b01, 1, 9'h051, 2'b01, 0));
    for (int i = 2; i <= 4; i++)
      vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'(8'h50 + i), 8'h00, 0, 9'h000, 2'b01, 1, 9'(9'h050 + i), 2'b00, 0));
    vecs.push_back(v(2'b01, 2'b00, 2'b00, 8'h55, 8'h00, 0, 9'h000, 2'b00, 0, 9'h054, 2'b00, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'(9'h050 + i), 2'b00, 0, 9'h054, 2'b01, 0));
    // M0 writes interleave with M1 reads and keep going once M1 is at its limit.
    for (int i = 0; i < 7; i++)
      vecs.push_back(v(2'b11, 2'b01, 2'b00, 8'h70, 8'h60, 0, 9'h000,
                       (i % 2 == 0) ? 2'b10 : 2'b01, 1, (i % 2 == 0) ? 9'h160 : 9'h070, 2'b00, 0));
    vecs.push_back(v(2'b11, 2'b01, 2'b00, 8'h70, 8'h60, 0, 9'h000, 2'b01, 1, 9'h070, 2'b00, 0));
    vecs.push_back(v(2'b11, 2'b01, 2'b00, 8'h70, 8'h60, 0, 9'h000, 2'b01, 1, 9'h070, 2'b00, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h160, 2'b00, 0, 9'h070, 2'b10, 0));
    // Response for M1 with nothing in flight.
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h1AA, 2'b00, 0, 9'h070, 2'b10, 1));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 9'h000, 2'b00, 0, 9'h070, 2'b00, 1));

    driveIdle();
    modelReset();
    reset_n = 0;
    @(posedge clock);
    #1;
    checkOutput();
    @(negedge clock);
    reset_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      check($sformatf("tbl%0d_ready", i), 32'({bus.m1_ready, bus.m0_ready}), 32'(vecs[i].rdy));
      @(posedge clock);
      #1;
      checkOutput();
      check($sformatf("tbl%0d_dec_request", i), 32'(bus.dec_request), 32'(vecs[i].dreq));
      check($sformatf("tbl%0d_dec_tag", i), 32'(bus.dec_tag), 32'(vecs[i].dtag));
      check($sformatf("tbl%0d_rvalid", i), 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(vecs[i].rvo));
      check($sformatf("tbl%0d_err_orphan", i), 32'(bus.err_orphan), 32'(vecs[i].err));
    end

    for (int i = 0; i < 150; i++) runCycle(randStim());

    // Asynchronous reset in the middle of a cycle clears every registered output at once.
    @(negedge clock);
    #2;
    reset_n = 0;
    #1;
    check("rst_dec_request", 32'(bus.dec_request), 0);
    check("rst_dec_write",   32'(bus.dec_write), 0);
    check("rst_dec_address", bus.dec_address, 0);
    check("rst_dec_wstrb",   32'(bus.dec_wstrb), 0);
    check("rst_dec_wdata",   bus.dec_wdata, 0);
    check("rst_dec_tag",     32'(bus.dec_tag), 0);
    check("rst_m0_rvalid",   32'(bus.m0_rvalid), 0);
    check("rst_m0_rdata",    bus.m0_rdata, 0);
    check("rst_m0_rtag",     32'(bus.m0_rtag), 0);
    check("rst_m1_rvalid",   32'(bus.m1_rvalid), 0);
    check("rst_m1_rdata",    bus.m1_rdata, 0);
    check("rst_m1_rtag",     32'(bus.m1_rtag), 0);
    check("rst_err_orphan",  32'(bus.err_orphan), 0);
    driveIdle();
    modelReset();
    @(negedge clock);
    reset_n = 1;

    // A response left over from before reset finds a zero count.
    runCycle(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1, 9'h012));
    check("late_resp_err_orphan", 32'(bus.err_orphan), 1);

    for (int i = 0; i < 150; i++) runCycle(randStim());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single CPU-side port of the address decoder between two requesters: M0 (CPU data port) and M1 (DMA/blitter).
- Round-robin arbitration with optional lock for back-to-back beats. Caps outstanding reads per master.
- Rewrites request tags so the decoder's read responses route back to the master that issued them.
- Sits directly upstream of the address decoder's cpu_dec_* port.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads in flight per master; range 1..15.
- M0_PRIORITY_ON_RESET, 1, round-robin pointer after reset: 1 = M0 wins first tie, 0 = M1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mN_request  in  1  master N request (N = 0,1); held until mN_ready
- mN_ready  out  1  request accepted this cycle (combinational)
- mN_write  in  1  1 = write
- mN_address  in  32  byte address
- mN_wstrb  in  4  write byte enables
- mN_wdata  in  32  write data
- mN_tag  in  8  master-local read tag
- mN_lock  in  1  keep grant after this beat
- mN_rvalid  out  1  read response valid
- mN_rdata  out  32  read data
- mN_rtag  out  8  master-local tag returned
- dec_request  out  1  to decoder request
- dec_write  out  1
- dec_address  out  32
- dec_wstrb  out  4
- dec_wdata  out  32
- dec_tag  out  9  {master_id, mN_tag}
- dec_rvalid  in  1  decoder response valid
- dec_rdata  in  32
- dec_rtag  in  9  bit 8 = master_id
- err_orphan  out  1  sticky: a response arrived for a master with zero outstanding reads

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - dec_request = 0; dec_write, dec_address, dec_wstrb, dec_wdata and dec_tag = 0.
  - mN_rvalid = 0, mN_rdata = 0, mN_rtag = 0.
  - Outstanding counters = 0, err_orphan = 0.
  - State = IDLE; RR pointer per M0_PRIORITY_ON_RESET.
- Eligibility: mN is eligible when mN_request = 1 and either it is a write or cnt_N < MAX_OUTSTANDING.
- Grant: at most one per cycle. mN_ready = grant_N, combinational from eligibility, state and pointer. No downstream backpressure, so a grant always completes.
- State machine:
  - IDLE: both eligible → pointer master wins. Only one eligible → it wins. After a grant, the pointer moves to the other master. Grant with mN_lock = 1 → LOCKED_N.
  - LOCKED_N: only master N may be granted; the other is masked even if eligible.
  - Leave LOCKED_N → IDLE on a granted beat with mN_lock = 0, or when mN_request = 0.
  - LOCKED_N where N is blocked only by its outstanding limit: stay locked and grant nobody.
- Request path: registered, 1-cycle latency.
  - Granted beat appears on dec_* the next cycle with dec_request = 1 and dec_tag = {N, mN_tag}.
  - No grant → dec_request = 0; other dec_* outputs hold their previous values.
- Response path: registered, 1-cycle latency.
  - dec_rvalid with dec_rtag[8] = N → next cycle mN_rvalid = 1, mN_rdata = dec_rdata, mN_rtag = dec_rtag[7:0].
  - The other master's rvalid stays 0.
  - Decoder delivers at most one response per cycle, so there are no response collisions.
- Counters (4-bit per master):
  - +1 on a granted read.
  - −1 on a response for that master.
  - Both in the same cycle → unchanged.
  - Response with cnt = 0 → counter stays 0, err_orphan sets and stays set until reset.
  - Counter never wraps.
- Writes: no counter change, no response expected.
- Reset mid-operation: in-flight responses are lost. After reset, the counters are 0; any late response sets err_orphan.

Decomposition:
- Package bus_pkg:
  - MASTER_ID_W = 1; TAG_W = 8; DEC_TAG_W = 9.
  - typedef bus_req_t {write, address, wstrb, wdata, tag}.
  - typedef bus_resp_t {rdata, rtag}.
  - typedef arb_state_t {IDLE, LOCKED_0, LOCKED_1}.
- One sub-module, outstanding_counter: per-master saturating up/down counter with full flag and orphan detect. Instantiate twice.

Test Plan:
- Both request reads every cycle, no lock, tags 0x10/0x20 → dec_tag alternates 0x010, 0x120; M0 granted first.
- M0 issues 4 reads (MAX_OUTSTANDING = 4) with no responses; M1 idle → 5th read stalls (m0_ready = 0). One response with dec_rtag = 0x003 → m0_rvalid next cycle with rtag 0x03, m0 granted the following cycle.
- M1 lock = 1 for 3 beats while M0 requests continuously → 3 consecutive M1 grants, then M0 granted on the beat after lock drops.
- Same-cycle M0 read grant and M0 response → cnt_0 unchanged.
- Simultaneous: a write from M0 interleaved with reads from M1 → write never blocked by M1's count.
- dec_rvalid with dec_rtag = 0x1AA while cnt_1 = 0 → m1_rvalid = 1, rtag 0xAA; err_orphan = 1 and stays set.
- Assert reset_n low mid-traffic → all outputs 0 immediately (async); counters 0 after release.
